// File: rtl/sha256_sched_pkg.sv
// rtl/sha256_sched_pkg.sv - shared types, constants and sigma helpers for the schedule expander
package sha256_sched_pkg;

   localparam int WORD_W     = 32;
   localparam int WIN_DEPTH  = 16;
   localparam int LOAD_WORDS = 16;

   typedef enum logic [1:0] {LOAD, EXPAND, DRAIN} state_t;

   // small sigma 0: ROTR7 ^ ROTR18 ^ SHR3
   function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   // small sigma 1: ROTR17 ^ ROTR19 ^ SHR10
   function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

endpackage

// File: rtl/req_sync.sv
// rtl/req_sync.sv - flop-chain synchroniser for the asynchronous ring request
module req_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // shift the asynchronous request through the metastability chain
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/msg_sched_rx.sv
// rtl/msg_sched_rx.sv - SHA-256 message schedule expander fed by a four-phase word ring
module msg_sched_rx
   import sha256_sched_pkg::*;
#(
   parameter int ROUNDS      = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              req,
   input  logic [WORD_W-1:0] din,
   output logic              ack,
   output logic [WORD_W-1:0] w_out,
   output logic [5:0]        w_idx,
   output logic              w_valid,
   input  logic              w_ready,
   output logic              done
);

   localparam logic [5:0] LAST_IDX  = 6'(ROUNDS - 1);
   localparam logic [5:0] LAST_LOAD = 6'(LOAD_WORDS - 1);

   state_t            state;
   logic [5:0]        cnt;
   logic [WORD_W-1:0] win [WIN_DEPTH];
   logic              req_s;
   logic              slot_free;
   logic              drain_done;
   logic              capture;
   logic              expand_step;
   logic [WORD_W-1:0] w_next;

   req_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk (clk),
      .rst_(rst_),
      .d   (req),
      .q   (req_s)
   );

   assign slot_free   = !w_valid || w_ready;
   assign drain_done  = (state == DRAIN) && w_valid && w_ready;
   // the last word leaving DRAIN frees the slot, so a waiting request may land on that same edge
   assign capture     = req_s && !ack && slot_free && ((state == LOAD) || drain_done);
   assign expand_step = (state == EXPAND) && slot_free;
   // win[15] is W[t-1], so win[14]=W[t-2], win[9]=W[t-7], win[1]=W[t-15], win[0]=W[t-16]
   assign w_next      = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

   // sliding window: shift in each new word, start a fresh all-zero window at block end
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         for (int i = 0; i < WIN_DEPTH; i++) win[i] <= '0;
      end else if (capture || expand_step) begin
         for (int i = 0; i < WIN_DEPTH - 1; i++) win[i] <= drain_done ? '0 : win[i+1];
         win[WIN_DEPTH-1] <= capture ? din : w_next;
      end else if (drain_done) begin
         for (int i = 0; i < WIN_DEPTH; i++) win[i] <= '0;
      end
   end

   // block sequencer with registered handshake and output-slot register
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state   <= LOAD;
         cnt     <= '0;
         ack     <= 1'b0;
         w_out   <= '0;
         w_idx   <= '0;
         w_valid <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!req_s) ack <= 1'b0;
         if (w_valid && w_ready) w_valid <= 1'b0;
         if (drain_done) begin
            done  <= 1'b1;
            cnt   <= '0;
            state <= LOAD;
         end
         if (capture) begin
            w_out   <= din;
            w_idx   <= drain_done ? 6'd0 : cnt;
            w_valid <= 1'b1;
            ack     <= 1'b1;
            cnt     <= drain_done ? 6'd1 : cnt + 6'd1;
            if (!drain_done && cnt == LAST_LOAD) state <= EXPAND;
         end else if (expand_step) begin
            w_out   <= w_next;
            w_idx   <= cnt;
            w_valid <= 1'b1;
            cnt     <= cnt + 6'd1;
            if (cnt == LAST_IDX) state <= DRAIN;
         end
      end
   end

endmodule

// File: tb/tb_msg_sched_rx.sv
// tb/tb_msg_sched_rx.sv - randomized self-checking bench for msg_sched_rx
module tb_msg_sched_rx;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic        req0 = 1'b0, ack0, wv0, wr0 = 1'b1, done0;
   logic [31:0] din0 = '0, wout0;
   logic [5:0]  widx0;
   logic        req17 = 1'b0, ack17, wv17, wr17 = 1'b1, done17;
   logic [31:0] din17 = '0, wout17;
   logic [5:0]  widx17;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   msg_sched_rx dut (
      .clk(clk), .rst_(rst_), .req(req0), .din(din0), .ack(ack0),
      .w_out(wout0), .w_idx(widx0), .w_valid(wv0), .w_ready(wr0), .done(done0)
   );

   msg_sched_rx #(.ROUNDS(17), .SYNC_STAGES(3)) dut17 (
      .clk(clk), .rst_(rst_), .req(req17), .din(din17), .ack(ack17),
      .w_out(wout17), .w_idx(widx17), .w_valid(wv17), .w_ready(wr17), .done(done17)
   );

   // reference schedule: straight from the SHA-256 message expansion recurrence
   logic [31:0] msg [16];
   logic [31:0] exp_q [$];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic void build_exp(input int rounds);
      logic [31:0] w [64];
      for (int t = 0; t < rounds; t++) begin
         if (t < 16) w[t] = msg[t];
         else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                   + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
         exp_q.push_back(w[t]);
      end
   endfunction

   // observation: accepted words, done pulses and protocol bookkeeping on the falling edge
   int          cyc = 0;
   logic [31:0] q_w0 [$], q_w17 [$];
   int          q_i0 [$], q_i17 [$], q_c0 [$], q_c17 [$], q_d0 [$], q_d17 [$];
   int          hold_viol = 0, held_ack_viol = 0, proto_viol = 0;
   int          ack_rises0 = 0, ack_rises17 = 0, pulses0 = 0, pulses17 = 0;
   logic        held = 1'b0, pack0 = 1'b0, preq0 = 1'b0, pack17 = 1'b0, preq17 = 1'b0;
   logic [31:0] hw = '0;
   logic [5:0]  hi = '0;
   bit          toggling = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (held && (wout0 !== hw || widx0 !== hi || wv0 !== 1'b1)) hold_viol++;
      if (held && ack0 && !pack0) held_ack_viol++;
      if (ack0 && !pack0) begin ack_rises0++; if (!preq0) proto_viol++; end
      if (!ack0 && pack0 && preq0) proto_viol++;
      if (ack17 && !pack17) begin ack_rises17++; if (!preq17) proto_viol++; end
      if (!ack17 && pack17 && preq17) proto_viol++;
      if (wv0 && wr0) begin q_w0.push_back(wout0); q_i0.push_back(int'(widx0)); q_c0.push_back(cyc); end
      if (wv17 && wr17) begin q_w17.push_back(wout17); q_i17.push_back(int'(widx17)); q_c17.push_back(cyc); end
      if (done0) q_d0.push_back(cyc);
      if (done17) q_d17.push_back(cyc);
      held = wv0 && !wr0; hw = wout0; hi = widx0;
      pack0 = ack0; preq0 = req0; pack17 = ack17; preq17 = req17;
   end

   function automatic logic get_ack(input int sel);
      return (sel == 0) ? ack0 : ack17;
   endfunction

   function automatic logic [31:0] qget0(input int i);
      return (i < q_w0.size()) ? q_w0[i] : 32'hxxxx_xxxx;
   endfunction

   task automatic clear_q();
      q_w0.delete(); q_i0.delete(); q_c0.delete(); q_d0.delete();
      q_w17.delete(); q_i17.delete(); q_c17.delete(); q_d17.delete();
      exp_q.delete();
   endtask

   task automatic drop_req(input int sel, input int maxd);
      int k;
      repeat ($urandom_range(0, maxd)) @(posedge clk);
      @(posedge clk); #($urandom_range(1, 3));
      if (sel == 0) req0 = 1'b0; else req17 = 1'b0;
      k = 0;
      while (get_ack(sel) !== 1'b0 && k < 500) begin @(posedge clk); #2; k++; end
      checks++;
      if (k >= 500) begin errors++; $display("FAIL ack_fall_timeout: ack=%b required 0", get_ack(sel)); end
   endtask

   task automatic send_word(input int sel, input logic [31:0] w, input int maxd);
      int k;
      repeat ($urandom_range(0, maxd)) @(posedge clk);
      @(posedge clk); #($urandom_range(1, 3));
      if (sel == 0) begin din0 = w; req0 = 1'b1; pulses0++; end
      else begin din17 = w; req17 = 1'b1; pulses17++; end
      k = 0;
      while (get_ack(sel) !== 1'b1 && k < 500) begin @(posedge clk); #2; k++; end
      checks++;
      if (k >= 500) begin errors++; $display("FAIL ack_rise_timeout: ack=%b required 1", get_ack(sel)); end
      drop_req(sel, maxd);
   endtask

   task automatic send_block(input int sel, input int maxd);
      for (int i = 0; i < 16; i++) send_word(sel, msg[i], maxd);
   endtask

   task automatic wait_done(input int sel, input int n);
      int k = 0;
      while (((sel == 0) ? q_d0.size() : q_d17.size()) < n && k < 3000) begin @(posedge clk); #1; k++; end
      checks++;
      if (k >= 3000) begin errors++; $display("FAIL done_timeout: got %0d done pulses required %0d", (sel == 0) ? q_d0.size() : q_d17.size(), n); end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_ = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ack0, wv0, done0, wout0, widx0} !== 41'b0) begin errors++;
         $display("FAIL reset_outputs: ack=%b valid=%b done=%b w_out=%h w_idx=%0d required all 0", ack0, wv0, done0, wout0, widx0); end
      checks++;
      if ({ack17, wv17, done17, wout17, widx17} !== 41'b0) begin errors++;
         $display("FAIL reset_outputs17: ack=%b valid=%b done=%b w_out=%h w_idx=%0d required all 0", ack17, wv17, done17, wout17, widx17); end
      @(posedge clk); #2; rst_ = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({ack0, wv0, done0} !== 3'b000) begin errors++; $display("FAIL idle_after_reset: ack/valid/done=%b required 000", {ack0, wv0, done0}); end
   endtask

   task automatic test_abc();
      int kidx [5] = '{16, 17, 18, 19, 63};
      logic [31:0] kval [5] = '{32'h61626380, 32'h000F0000, 32'h7DA86405, 32'h600003C6, 32'h12B1EDEB};
      clear_q();
      msg[0] = 32'h61626380;
      for (int i = 1; i < 15; i++) msg[i] = '0;
      msg[15] = 32'h00000018;
      build_exp(64);
      send_block(0, 2);
      wait_done(0, 1);
      checks++;
      if (q_w0.size() != 64) begin errors++; $display("FAIL abc_count: got %0d words required 64", q_w0.size()); end
      for (int i = 0; i < 64 && i < q_w0.size(); i++) begin
         checks++;
         if (q_w0[i] !== exp_q[i] || q_i0[i] != i) begin errors++;
            $display("FAIL abc_word[%0d]: got idx %0d w %h required idx %0d w %h", i, q_i0[i], q_w0[i], i, exp_q[i]); end
      end
      for (int j = 0; j < 5; j++) begin
         checks++;
         if (qget0(kidx[j]) !== kval[j]) begin errors++;
            $display("FAIL abc_known_W%0d: got %h required %h", kidx[j], qget0(kidx[j]), kval[j]); end
      end
      checks++;
      if (q_d0.size() != 1 || q_c0.size() < 64 || q_d0[0] != q_c0[63] + 1) begin errors++;
         $display("FAIL abc_done_timing: %0d pulses, first at cycle %0d, required 1 pulse at cycle after idx63 accept", q_d0.size(), (q_d0.size() > 0) ? q_d0[0] : -1); end
   endtask

   task automatic test_backpressure();
      clear_q();
      hold_viol = 0; held_ack_viol = 0;
      msg[0] = 32'h61626380;
      for (int i = 1; i < 15; i++) msg[i] = '0;
      msg[15] = 32'h00000018;
      build_exp(64);
      toggling = 1'b1;
      fork
         begin
            while (toggling) begin @(posedge clk); #1; wr0 = ~wr0; end
            wr0 = 1'b1;
         end
      join_none
      send_block(0, 2);
      wait_done(0, 1);
      toggling = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (q_w0.size() != 64) begin errors++; $display("FAIL bp_count: got %0d words required 64", q_w0.size()); end
      for (int i = 0; i < 64 && i < q_w0.size(); i++) begin
         checks++;
         if (q_w0[i] !== exp_q[i] || q_i0[i] != i) begin errors++;
            $display("FAIL bp_word[%0d]: got idx %0d w %h required idx %0d w %h", i, q_i0[i], q_w0[i], i, exp_q[i]); end
      end
      checks++;
      if (hold_viol != 0) begin errors++; $display("FAIL bp_hold: %0d cycles output changed while stalled, required 0", hold_viol); end
      checks++;
      if (held_ack_viol != 0) begin errors++; $display("FAIL bp_ack_while_held: %0d ack rises with slot held, required 0", held_ack_viol); end
      checks++;
      if (q_d0.size() != 1 || q_c0.size() < 64 || q_d0[0] != q_c0[63] + 1) begin errors++;
         $display("FAIL bp_done_timing: %0d pulses, required 1 pulse one cycle after idx63 accept", q_d0.size()); end
   endtask

   task automatic test_early_req();
      logic [31:0] b [16];
      int k;
      clear_q();
      for (int i = 0; i < 16; i++) msg[i] = $urandom;
      build_exp(64);
      send_block(0, 1);
      for (int i = 0; i < 16; i++) b[i] = $urandom;
      @(posedge clk); #1;
      din0 = b[0]; req0 = 1'b1; pulses0++;
      checks++;
      if (q_w0.size() < 16 || q_w0.size() > 62) begin errors++;
         $display("FAIL early_req_timing: %0d words out when req raised, required 16..62 (expanding)", q_w0.size()); end
      k = 0;
      while (ack0 !== 1'b1 && k < 500) begin @(posedge clk); #1; k++; end
      checks++;
      if (ack0 !== 1'b1 || done0 !== 1'b1 || widx0 !== 6'd0 || wout0 !== b[0]) begin errors++;
         $display("FAIL early_req_capture: ack=%b done=%b w_idx=%0d w_out=%h required ack=1 done=1 idx=0 w=%h", ack0, done0, widx0, wout0, b[0]); end
      drop_req(0, 0);
      for (int i = 0; i < 16; i++) msg[i] = b[i];
      build_exp(64);
      for (int i = 1; i < 16; i++) send_word(0, b[i], 1);
      wait_done(0, 2);
      checks++;
      if (q_w0.size() != 128) begin errors++; $display("FAIL early_count: got %0d words required 128", q_w0.size()); end
      for (int i = 0; i < 128 && i < q_w0.size(); i++) begin
         checks++;
         if (q_w0[i] !== exp_q[i] || q_i0[i] != i % 64) begin errors++;
            $display("FAIL early_word[%0d]: got idx %0d w %h required idx %0d w %h", i, q_i0[i], q_w0[i], i % 64, exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid();
      clear_q();
      for (int i = 0; i < 16; i++) msg[i] = $urandom | 32'h1;
      for (int i = 0; i < 10; i++) send_word(0, msg[i], 1);
      @(posedge clk); #2;
      rst_ = 1'b0;
      #1;
      checks++;
      if ({ack0, wv0, done0} !== 3'b000) begin errors++; $display("FAIL rst_mid_ctrl: ack/valid/done=%b required 000", {ack0, wv0, done0}); end
      checks++;
      if ({wout0, widx0} !== 38'b0) begin errors++; $display("FAIL rst_mid_data: w_out=%h w_idx=%0d required 0", wout0, widx0); end
      @(posedge clk); #2;
      rst_ = 1'b1;
      clear_q();
      for (int i = 0; i < 16; i++) msg[i] = $urandom;
      build_exp(64);
      send_block(0, 2);
      wait_done(0, 1);
      checks++;
      if (q_w0.size() != 64) begin errors++; $display("FAIL rst_mid_count: got %0d words required 64", q_w0.size()); end
      for (int i = 0; i < 64 && i < q_w0.size(); i++) begin
         checks++;
         if (q_w0[i] !== exp_q[i] || q_i0[i] != i) begin errors++;
            $display("FAIL rst_mid_word[%0d]: got idx %0d w %h required idx %0d w %h", i, q_i0[i], q_w0[i], i, exp_q[i]); end
      end
   endtask

   task automatic test_rounds17();
      clear_q();
      for (int blk = 0; blk < 2; blk++) begin
         for (int i = 0; i < 16; i++) msg[i] = $urandom;
         build_exp(17);
         send_block(1, 2);
         wait_done(1, blk + 1);
      end
      checks++;
      if (q_w17.size() != 34) begin errors++; $display("FAIL r17_count: got %0d words required 34", q_w17.size()); end
      for (int i = 0; i < 34 && i < q_w17.size(); i++) begin
         checks++;
         if (q_w17[i] !== exp_q[i] || q_i17[i] != i % 17) begin errors++;
            $display("FAIL r17_word[%0d]: got idx %0d w %h required idx %0d w %h", i, q_i17[i], q_w17[i], i % 17, exp_q[i]); end
      end
      for (int j = 0; j < 2; j++) begin
         checks++;
         if (q_d17.size() != 2 || q_c17.size() < 34 || q_d17[j] != q_c17[17*j + 16] + 1) begin errors++;
            $display("FAIL r17_done_timing[%0d]: %0d pulses, required one pulse right after idx16 accept", j, q_d17.size()); end
      end
   endtask

   task automatic test_protocol();
      clear_q();
      for (int i = 0; i < 16; i++) msg[i] = $urandom;
      build_exp(64);
      send_block(0, 6);
      wait_done(0, 1);
      checks++;
      if (q_w0.size() != 64) begin errors++; $display("FAIL proto_count: got %0d words required 64", q_w0.size()); end
      for (int i = 0; i < 64 && i < q_w0.size(); i++) begin
         checks++;
         if (q_w0[i] !== exp_q[i] || q_i0[i] != i) begin errors++;
            $display("FAIL proto_word[%0d]: got idx %0d w %h required idx %0d w %h", i, q_i0[i], q_w0[i], i, exp_q[i]); end
      end
      checks++;
      if (proto_viol != 0) begin errors++; $display("FAIL proto_order: %0d ack edges out of order with req, required 0", proto_viol); end
      checks++;
      if (ack_rises0 != pulses0) begin errors++; $display("FAIL proto_captures: %0d ack rises for %0d req pulses, required equal", ack_rises0, pulses0); end
      checks++;
      if (ack_rises17 != pulses17) begin errors++; $display("FAIL proto_captures17: %0d ack rises for %0d req pulses, required equal", ack_rises17, pulses17); end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_backpressure();
      test_early_req();
      test_reset_mid();
      test_rounds17();
      test_protocol();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/msg_sched_rx.md
# msg_sched_rx

Clocked SHA-256 message-schedule expander on the consumer side of the asynchronous word ring. It receives 32-bit message words over a four-phase req/ack channel, synchronises the request into the `clk` domain, and keeps a 16-word sliding window. It emits W[0..15] as received and then computes W[16..ROUNDS-1] locally, presenting every word on a valid/ready output port for the compression stage.

## Interface
- `ROUNDS`, default 64: total schedule words per block; legal range 17..64.
- `SYNC_STAGES`, default 2: flops in the `req` synchroniser; minimum 2.

Ports:
- `clk`  in  1  single clock
- `rst_`  in  1  asynchronous, active-low reset
- `req`  in  1  four-phase request from the ring; asynchronous to `clk`
- `din`  in  32  message word; stable from `req` rise until `ack` rise
- `ack`  out  1  four-phase acknowledge to the ring; registered
- `w_out`  out  32  schedule word W[t]
- `w_idx`  out  6  t of `w_out`
- `w_valid`  out  1  `w_out`/`w_idx` hold a word
- `w_ready`  in  1  downstream accepts the word this cycle
- `done`  out  1  one-cycle pulse when word ROUNDS-1 is accepted

## Operation
- **Reset (`rst_`=0, any time, takes effect immediately).**
  - State LOAD, `cnt`=0, window all zero, synchroniser zero.
  - `ack`=0, `w_valid`=0, `w_out`=0, `w_idx`=0, `done`=0.
  - A partial block is discarded.
- **Output slot.** Free when `w_valid`=0 or when `w_valid`&`w_ready` in this cycle.
- **`req_s`.** Output of the synchroniser.
- **LOAD (`cnt` 0..15).**
  - Capture when `req_s`=1, `ack`=0 and the slot is free.
  - On capture: `din` is shifted into the window; `w_out`=`din`, `w_idx`=`cnt`, `w_valid`=1; `ack`=1; `cnt`++.
  - After capturing word 15, go to EXPAND.
- **Ack release.** `ack` falls on the first edge with `req_s`=0, in any state. A new capture requires `ack`=0.
- **EXPAND (`cnt` 16..ROUNDS-1).**
  - Each cycle the slot is free, compute W = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32. win[15] is the newest word, W[t-1].
  - σ0 = ROTR7 ^ ROTR18 ^ SHR3; σ1 = ROTR17 ^ ROTR19 ^ SHR10.
  - Load W into the output register, shift it into the window, `cnt`++.
  - After producing word ROUNDS-1, go to DRAIN.
  - `req` is never captured in EXPAND; the ring stalls with `ack`=0.
- **DRAIN.**
  - When the last word is accepted: `done`=1 for one cycle, `cnt`=0, window cleared, back to LOAD.
  - A pending `req_s` may be captured in the same cycle the last word drains, because the slot is free.
- **Backpressure.** When `w_ready`=0, `w_out`/`w_idx`/`w_valid` hold and nothing is captured or computed.

## Timing
- `req` to `req_s` latency: SYNC_STAGES cycles.
- From `req_s` high with a free slot:
  - `ack` and `w_valid` rise on the same edge;
  - `ack` is seen by the ring one clock after capture.
- Full handshake per LOAD word: at least 2·SYNC_STAGES+2 cycles.
- EXPAND throughput: one word per cycle with `w_ready` held high.
- `w_idx` is strictly increasing, 0..ROUNDS-1, with no gaps or repeats.
- `done` is asserted in the cycle after the W[ROUNDS-1] acceptance edge.
- `din` is sampled only on the capture edge. The ring guarantees stability across synchroniser latency because `ack` is still low.

## Structure
- Package `sha256_sched_pkg` holds:
  - state enum {LOAD, EXPAND, DRAIN};
  - functions `sigma0`/`sigma1`;
  - `WORD_W`=32, `WIN_DEPTH`=16, `LOAD_WORDS`=16.
- Sub-module `req_sync`: SYNC_STAGES-deep flop chain with async active-low clear, used for `req`.
- The top level contains the FSM, the window shift register, the adder tree and the output register.

## Test plan
- **"abc" block, `w_ready`=1.** Send W0=0x61626380, W1..W14=0, W15=0x00000018. Required outputs:
  - W0..W15 echoed;
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6, W63=0x12B1EDEB;
  - `done` one cycle after the idx 63 acceptance.
- **Backpressure.** Same block with `w_ready` toggling 1/0 each cycle. Required:
  - identical word sequence;
  - `w_out` stable whenever `valid`&!`ready`;
  - `ack` never rises while the slot is held.
- **Early request.** Assert `req` for word 0 of a second block during EXPAND. Required:
  - `ack` stays 0 until the DRAIN acceptance;
  - then the block is captured as idx 0 with an all-zero window.
- **Reset mid-block.** Pull `rst_` low after W9 is acked and `req` is low. Required:
  - all outputs 0 immediately;
  - the next block restarts at `w_idx`=0 and produces correct W16.
- **ROUNDS=17.** Required: exactly 17 words, `done` after idx 16, then return to LOAD.
- **Four-phase protocol check.** Randomised `req` delays across the ring. Required:
  - `ack` rises only after `req` rises;
  - `ack` falls only after `req` falls;
  - never two captures per `req` pulse.
